// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC constants, arctangent table and control-state encoding.
// Angles are in degrees scaled by 2^16; the vectoring block reuses the same table.
package cordic_pkg;
    localparam int ATAN_N = 16;
    localparam logic signed [31:0] K_GAIN = 32'sd39797;
    localparam logic signed [31:0] DEG90  = 32'sd5898240;
    localparam logic signed [31:0] DEG180 = 32'sd11796480;
    localparam logic signed [31:0] ATAN_TAB [ATAN_N] = '{
        32'sd2949120, 32'sd1740992, 32'sd919872, 32'sd466944,
        32'sd234368,  32'sd117312,  32'sd58688,  32'sd29312,
        32'sd14656,   32'sd7360,    32'sd3648,   32'sd1856,
        32'sd896,     32'sd448,     32'sd256,    32'sd128
    };
    typedef enum logic [1:0] {IDLE, PRE, WORK, DONE} state_t;
endpackage

// File: rtl/cordic_rot_stage.sv
// cordic_rot_stage: one combinational rotation-mode CORDIC micro-rotation.
// Kept free of control so it can be replicated for an unrolled pipeline.
module cordic_rot_stage
    import cordic_pkg::*;
(
    input  logic signed [31:0] x,
    input  logic signed [31:0] y,
    input  logic signed [31:0] z,
    input  logic        [3:0]  cnt,
    output logic signed [31:0] x_nxt,
    output logic signed [31:0] y_nxt,
    output logic signed [31:0] z_nxt
);
    logic signed [31:0] xs, ys, a;
    logic pos;
    always_comb begin
        pos   = !z[31];
        xs    = x >>> cnt;
        ys    = y >>> cnt;
        a     = ATAN_TAB[cnt];
        x_nxt = pos ? x - ys : x + ys;
        y_nxt = pos ? y + xs : y - xs;
        z_nxt = pos ? z - a : z + a;
    end
endmodule

// File: rtl/cordic_rotate.sv
// cordic_rotate: iterative rotation-mode CORDIC, polar (mag, phase in degrees Q16.16)
// to rectangular (x = mag*cos, y = mag*sin), one micro-rotation per clock.
module cordic_rotate
    import cordic_pkg::*;
#(
    parameter int MAG_W = 24,
    parameter int ITER  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic        [MAG_W-1:0] mag_in,
    input  logic signed [31:0]      phase_in,
    output logic                    out_valid,
    output logic signed [31:0]      x_out,
    output logic signed [31:0]      y_out,
    output logic                    out_err
);
    state_t state, state_nxt;
    logic [3:0] cnt;
    logic [MAG_W-1:0] mag;
    logic [47:0] prod;
    logic signed [31:0] phase, x, y, z, x_nxt, y_nxt, z_nxt, scaled, x0, z0;
    logic err_flag, oor, fold, last;

    assign in_ready = state == IDLE;
    assign last     = cnt == 4'(ITER - 1);

    // Fold phases beyond +/-90 deg by 180 deg and flip the start vector to compensate
    always_comb begin
        prod   = 48'(mag) * 48'(K_GAIN);
        scaled = 32'(prod >> 16);
        oor    = phase > DEG180 || phase < -DEG180;
        fold   = phase > DEG90 || phase < -DEG90;
        z0     = oor ? '0 : phase > DEG90 ? phase - DEG180 : phase < -DEG90 ? phase + DEG180 : phase;
        x0     = oor ? '0 : fold ? -scaled : scaled;
    end

    always_comb begin
        state_nxt = state == IDLE ? (in_valid ? PRE : IDLE) :
                    state == PRE  ? WORK :
                    state == WORK ? (last ? DONE : WORK) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt       <= '0;
            mag       <= '0;
            phase     <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            err_flag  <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= state == DONE;
            if (in_valid && in_ready) begin
                mag   <= mag_in;
                phase <= phase_in;
            end
            if (state == PRE) begin
                x        <= x0;
                y        <= '0;
                z        <= z0;
                err_flag <= oor;
                cnt      <= '0;
            end
            if (state == WORK) begin
                x   <= x_nxt;
                y   <= y_nxt;
                z   <= z_nxt;
                cnt <= last ? '0 : cnt + 4'd1;
            end
            if (state == DONE) begin
                x_out   <= x;
                y_out   <= y;
                out_err <= err_flag;
            end
        end

    cordic_rot_stage u_stage (
        .x     (x),
        .y     (y),
        .z     (z),
        .cnt   (cnt),
        .x_nxt (x_nxt),
        .y_nxt (y_nxt),
        .z_nxt (z_nxt)
    );
endmodule

// File: tb/tb_cordic_rotate.sv
// tb_cordic_rotate: scoreboard bench for cordic_rotate against a real-arithmetic
// cos/sin reference, plus latency, handshake and mid-operation reset checks.
module tb_cordic_rotate;
    localparam int MAG_W = 24;
    localparam int ITER  = 16;
    localparam int LAT   = ITER + 2;
    localparam int D180  = 11796480;

    typedef struct {
        int ex;
        int ey;
        int err;
        int tol;
        int acc;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
    logic in_ready, out_valid, out_err;
    logic [MAG_W-1:0] mag_in = '0;
    logic signed [31:0] phase_in = '0, x_out, y_out;
    exp_t sb[$];
    int cyc = 0, compared = 0, mismatched = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    cordic_rotate #(.MAG_W(MAG_W), .ITER(ITER)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mag_in    (mag_in),
        .phase_in  (phase_in),
        .out_valid (out_valid),
        .x_out     (x_out),
        .y_out     (y_out),
        .out_err   (out_err)
    );

    task automatic check(string tag, int got, int want, int tol);
        compared++;
        if ((got > want ? got - want : want - got) > tol) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (+/- %0d)", tag, got, want, tol);
        end
    endtask

    function automatic exp_t model(int mag, int ph, int acc);
        exp_t e;
        real a;
        a     = real'(ph) / 65536.0 * 3.14159265358979 / 180.0;
        e.acc = acc;
        e.err = (ph > D180 || ph < -D180) ? 1 : 0;
        e.ex  = e.err != 0 ? 0 : int'(real'(mag) * $cos(a));
        e.ey  = e.err != 0 ? 0 : int'(real'(mag) * $sin(a));
        e.tol = e.err != 0 ? 0 : (mag + 999) / 1000 + 4;
        return e;
    endfunction

    always @(negedge clk)
        if (out_valid) begin : mon
            exp_t e;
            if (sb.size() == 0) check("spurious_valid", 1, 0, 0);
            else begin
                e = sb.pop_front();
                check("x_out", x_out, e.ex, e.tol);
                check("y_out", y_out, e.ey, e.tol);
                check("out_err", int'(out_err), e.err, 0);
                check("latency", cyc - e.acc, LAT, 0);
            end
        end

    task automatic send(int mag, int ph);
        int k = 0;
        @(negedge clk);
        in_valid = 1'b1;
        mag_in   = MAG_W'(mag);
        phase_in = ph;
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("accept", int'(in_ready), 1, 0);
        if (in_ready) sb.push_back(model(mag, ph, cyc + 1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("drain", sb.size(), 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last = -100;
        repeat (2) @(negedge clk);
        check("rst_valid", int'(out_valid), 0, 0);
        check("rst_x", x_out, 0, 0);
        check("rst_y", y_out, 0, 0);
        check("rst_err", int'(out_err), 0, 0);
        check("rst_ready", int'(in_ready), 1, 0);
        rst_n = 1'b1;

        send(10000, 0);
        drain();
        send(65536, 5898240);
        send(1000, -8847360);
        send(1000, D180);
        send(1000, 13107200);
        send(1000, -13107200);
        send(1000, -5898240);
        send(1000, -D180);
        send(0, 1234567);
        for (int i = 0; i < 4; i++)
            send(int'($urandom_range(1, (1 << 23) - 1)), int'($urandom_range(0, 2 * D180)) - D180);
        drain();

        // Hold in_valid with fresh data every cycle; only ready cycles are accepted
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            mag_in   = MAG_W'(5000 + i * 100);
            phase_in = (i * 7 - 150) * 65536;
            check("in_ready", int'(in_ready), (i - last >= ITER + 3) ? 1 : 0, 0);
            if (i - last >= ITER + 3) begin
                sb.push_back(model(5000 + i * 100, (i * 7 - 150) * 65536, cyc + 1));
                last = i;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        send(20000, 30 * 65536);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0, 0);
        check("mid_rst_x", x_out, 0, 0);
        check("mid_rst_y", y_out, 0, 0);
        check("mid_rst_ready", int'(in_ready), 1, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        send(30000, -60 * 65536);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/cordic_rotate.md
Name: cordic_rotate

Overview:
- Iterative CORDIC in rotation mode: polar-to-rectangular conversion, the inverse of the vectoring-mode magnitude/phase block.
- Takes an unsigned magnitude and a signed phase in degrees (Q16.16), and returns signed x = mag*cos(phase) and y = mag*sin(phase).
- Sits downstream of phase/amplitude processing in the CORDIC datapath.
- One shift-add iteration per clock, with a valid/ready input handshake.

Parameters:
- MAG_W, 24: magnitude input width in bits, unsigned; must be at most 30.
- ITER, 16: number of CORDIC iterations, legal range 8..16; the angle table has 16 entries.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input request.
- in_ready  out  1  high while the block can accept an input.
- mag_in  in  MAG_W  unsigned magnitude.
- phase_in  in  32  signed phase, degrees*2^16.
- out_valid  out  1  one-cycle result strobe.
- x_out  out  32  signed cosine component.
- y_out  out  32  signed sine component.
- out_err  out  1  set with out_valid when phase_in was out of range.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: x_out=0, y_out=0, out_valid=0, out_err=0, state=IDLE, cnt=0.
- States: IDLE -> PRE -> WORK -> DONE -> IDLE.
- Handshake: in_ready = (state==IDLE), decoded combinationally from the state register. An input is accepted on a clk edge with in_valid && in_ready. mag_in and phase_in are captured on that edge.
- No backpressure on the output. out_valid is a single-cycle strobe; a result not sampled is lost.
- PRE (1 cycle): quadrant fold and gain pre-scale.
  - K = 39797 (0.60725*2^16). x0 = (mag*K)>>>16 and y0 = 0.
  - If phase > 90° (5898240): z0 = phase - 180° (11796480) and x0 is negated.
  - If phase < -90°: z0 = phase + 180° and x0 is negated.
  - Otherwise z0 = phase.
  - Legal range is -11796480..+11796480 inclusive. Outside that range, err_flag is latched, and the block still runs with z0=0 and x0=0.
- WORK (ITER cycles, cnt = 0..ITER-1):
  - d = +1 if z >= 0, else -1.
  - x <= x - d*(y>>>cnt); y <= y + d*(x>>>cnt); z <= z - d*atan_tab[cnt].
  - All shifts are arithmetic. Registers are 32-bit signed with no saturation; MAG_W <= 30 guarantees no overflow.
  - When cnt == ITER-1: go to DONE, cnt <= 0.
- DONE (1 cycle): x_out<=x, y_out<=y, out_err<=err_flag, out_valid<=1; next state IDLE.
- Output registers hold their values until the next DONE.
- Latency: out_valid is high during the cycle after the (ITER+2)th rising edge following the accept edge. For ITER=16 that is 18 edges after accept.
- Throughput: one result per ITER+3 cycles. A new accept is possible in the same cycle that out_valid is high.
- Accuracy (ITER=16): |error| <= 0.1% of mag + 4 LSB per component.
- Boundary cases:
  - in_valid while busy is ignored; in_ready=0, and the input is not queued.
  - Exactly ±90° takes the no-fold path.
  - Exactly ±180° folds to z0=0.
  - mag=0 gives x=y=0.
- Reset mid-operation: the in-flight computation is discarded, no out_valid is produced, and outputs return to 0 immediately.
- atan table, degrees*2^16, index 0..15: 2949120, 1740992, 919872, 466944, 234368, 117312, 58688, 29312, 14656, 7360, 3648, 1856, 896, 448, 256, 128.

Decomposition:
- Package cordic_pkg: the atan table constant, K_GAIN=39797, DEG90=5898240, DEG180=11796480, and the state encoding. The vectoring block reuses the same table and constants.
- One natural sub-module: cordic_rot_stage, the combinational single-iteration datapath (x, y, z, cnt in; next x, y, z out). It keeps the FSM/control separate and allows a future pipelined unrolled variant.

Test Plan:
- Quadrant-0 baseline: mag=10000, phase=0 -> x_out≈10000 (±14), y_out≈0 (±14), out_err=0; out_valid exactly 18 cycles after accept.
- 90° point: mag=65536, phase=5898240 -> x≈0, y≈65536 (±70).
- Fold path: mag=1000, phase=-8847360 (-135°) -> x≈-707, y≈-707 (±5). Repeat with phase=+11796480 (180°) -> x≈-1000, y≈0.
- Out-of-range phase: mag=1000, phase=13107200 (200°) -> out_err=1, x_out=0, y_out=0.
- Handshake: hold in_valid high with changing data -> in_ready low during PRE, WORK and DONE; only inputs at in_ready=1 edges are accepted; one result per 19 cycles; the busy-period input is dropped.
- Reset mid-operation: assert rst_n low at WORK cnt=7 -> out_valid, x_out and y_out go to 0 asynchronously, no stale out_valid afterwards, and the next accepted input computes correctly.
